// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state codes, port ids and
// the default RAM geometry also used by ram and mar.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RDAT = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_EXT = 1'b1
    } gnt_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker: round-robin between CPU and EXT, with a
// bounded EXT priority window while ext_lock is held.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs_i,       // {ext, cpu}
    input  gnt_e       last_gnt_i,
    input  logic       ext_lock_i,
    input  logic       lock_max_i,
    output logic       gnt_valid_o,
    output gnt_e       gnt_id_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_valid_o = |reqs_i;
        gnt_id_o    = GNT_CPU;
        if (reqs_i == 2'b10) begin
            gnt_id_o = GNT_EXT;
        end else if (reqs_i == 2'b11) begin
            if (ext_lock_i) begin
                gnt_id_o = lock_max_i ? GNT_CPU : GNT_EXT;
            end else begin
                gnt_id_o = (last_gnt_i == GNT_CPU) ? GNT_EXT : GNT_CPU;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU datapath and the EXT loader port,
// sequencing each access through the RAM's one-cycle registered read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic              ext_lock_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_ack_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic              busy_o
);

    localparam int CNT_W = 4;

    state_e            state_q;
    gnt_e              owner_q, last_gnt_q;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, ram_we_q, cpu_ack_q, ext_ack_q;

    logic              gnt_valid, lock_max;
    gnt_e              gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    assign lock_max = (lock_cnt_q == CNT_W'(MAX_LOCK));

    arb_rr_pick u_pick (
        .reqs_i      ({ext_req_i, cpu_req_i}),
        .last_gnt_i  (last_gnt_q),
        .ext_lock_i  (ext_lock_i),
        .lock_max_i  (lock_max),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign sel_addr  = (gnt_id == GNT_EXT) ? ext_addr_i  : cpu_addr_i;
    assign sel_wdata = (gnt_id == GNT_EXT) ? ext_wdata_i : cpu_wdata_i;
    assign sel_we    = (gnt_id == GNT_EXT) ? ext_we_i    : cpu_we_i;

    // The lock window clears on any CPU grant and whenever ext_lock drops, in any state.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == IDLE && gnt_valid) begin
            if (gnt_id == GNT_CPU) begin
                lock_cnt_d = '0;
            end else if (ext_lock_i && !lock_max) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
        if (!ext_lock_i) begin
            lock_cnt_d = '0;
        end
    end

    // Acks and ram_we are registered on entry to the state that presents them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= GNT_CPU;
            last_gnt_q <= GNT_EXT;
            lock_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ram_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ext_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            cpu_ack_q  <= 1'b0;
            ext_ack_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            lock_cnt_q <= lock_cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q    <= ACC;
                        owner_q    <= gnt_id;
                        last_gnt_q <= gnt_id;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        we_q       <= sel_we;
                        ram_we_q   <= sel_we;
                        cpu_ack_q  <= sel_we && (gnt_id == GNT_CPU);
                        ext_ack_q  <= sel_we && (gnt_id == GNT_EXT);
                    end
                end
                ACC: begin
                    state_q   <= we_q ? IDLE : RDAT;
                    cpu_ack_q <= !we_q && (owner_q == GNT_CPU);
                    ext_ack_q <= !we_q && (owner_q == GNT_EXT);
                end
                RDAT:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign ram_we_o    = ram_we_q;
    assign busy_o      = (state_q != IDLE);
    assign cpu_ack_o   = cpu_ack_q;
    assign ext_ack_o   = ext_ack_q;
    assign cpu_rdata_o = (cpu_ack_q && !we_q) ? ram_q_i : '0;
    assign ext_rdata_o = (ext_ack_q && !we_q) ? ram_q_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a RAM model, per-port drivers, and a
// monitor checking grant order (from the arbitration rules) and read data (from a shadow memory).
module tb_mem_port_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int MAXL = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_we, ext_lock, ext_ack;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_we, busy;

    logic [DW-1:0] ram_mem [512] = '{default: '0};
    logic [DW-1:0] shadow  [512] = '{default: '0};
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    exp_t cpu_q[$];
    exp_t ext_q[$];
    int   gnt_exp[$];
    int   ack_log[$];
    int   m_last, m_cnt, m_w;
    int   we_cnt;
    logic [AW-1:0] we_addr, last_ack_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .ext_req_i   (ext_req),
        .ext_we_i    (ext_we),
        .ext_lock_i  (ext_lock),
        .ext_addr_i  (ext_addr),
        .ext_wdata_i (ext_wdata),
        .ext_ack_o   (ext_ack),
        .ext_rdata_o (ext_rdata),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data),
        .ram_we_o    (ram_we),
        .ram_q_i     (ram_q),
        .busy_o      (busy)
    );

    // Single-port RAM with registered read, plus a backdoor preload path.
    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void init_model();
        gnt_exp.delete();
        cpu_q.delete();
        ext_q.delete();
        ack_log.delete();
        m_last = 1;
        m_cnt  = 0;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        shadow[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        init_model();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output int lat);
        exp_t e;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        e.we = we; e.addr = a; e.data = we ? d : shadow[a];
        if (we) shadow[a] = d;
        cpu_q.push_back(e);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 60);
        if (!cpu_ack) check("cpu_ack_timeout", 32'(lat), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic ext_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic lock, output int lat);
        exp_t e;
        ext_we = we; ext_addr = a; ext_wdata = d; ext_lock = lock; ext_req = 1'b1;
        e.we = we; e.addr = a; e.data = we ? d : shadow[a];
        if (we) shadow[a] = d;
        ext_q.push_back(e);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ext_ack && lat < 60);
        if (!ext_ack) check("ext_ack_timeout", 32'(lat), 32'd0);
        @(posedge clk); #1;
        ext_req = 1'b0; ext_lock = 1'b0;
    endtask

    task automatic port_ack(input int p);
        exp_t e;
        int   g;
        ack_log.push_back(p);
        if (gnt_exp.size() == 0) begin
            check("unexpected_ack", 32'(p), 32'hFFFF_FFFF);
        end else begin
            g = gnt_exp.pop_front();
            check("grant_port", 32'(p), 32'(g));
        end
        if ((p == 0 && cpu_q.size() == 0) || (p == 1 && ext_q.size() == 0)) begin
            check("ack_without_request", 32'(p), 32'hFFFF_FFFF);
        end else begin
            e = (p == 0) ? cpu_q.pop_front() : ext_q.pop_front();
            last_ack_addr = e.addr;
            if (e.we) begin
                check("wr_ack_ram_we", 32'(ram_we), 32'd1);
                check("wr_ack_ram_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_ack_ram_data", ram_data, e.data);
            end else begin
                check("rd_ack_ram_we", 32'(ram_we), 32'd0);
                check(p == 0 ? "cpu_rdata" : "ext_rdata", p == 0 ? cpu_rdata : ext_rdata, e.data);
            end
        end
    endtask

    // Monitor: predicts each grant from the arbitration rules and checks every ack.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!busy && (cpu_req || ext_req)) begin
                    if (!ext_req)      m_w = 0;
                    else if (!cpu_req) m_w = 1;
                    else if (ext_lock) m_w = (m_cnt >= MAXL) ? 0 : 1;
                    else               m_w = 1 - m_last;
                    gnt_exp.push_back(m_w);
                    m_last = m_w;
                    if (m_w == 0) m_cnt = 0;
                    else if (ext_lock) m_cnt = (m_cnt < MAXL) ? m_cnt + 1 : MAXL;
                end
                if (!ext_lock) m_cnt = 0;
                if (cpu_ack && ext_ack) check("dual_ack", 32'd1, 32'd0);
                if (cpu_ack) port_ack(0);
                if (ext_ack) port_ack(1);
                if (ram_we) begin
                    we_cnt++;
                    we_addr = ram_addr;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [DW-1:0] d;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_lock = 1'b0;
        we_cnt = 0; we_addr = '0; last_ack_addr = '0;
        init_model();

        // 1: outputs quiet under reset even with both requests high, then a CPU read.
        rst_n = 1'b0; cpu_req = 1'b1; ext_req = 1'b1; cpu_addr = 9'h010; ext_addr = 9'h011;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_ext_ack", 32'(ext_ack), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0; ext_req = 1'b0;
        preload(9'h010, 32'hDEAD_BEEF);
        init_model();
        rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_access(1'b0, 9'h010, '0, lat);
        check("t1_read_latency", 32'(lat), 32'd3);

        // 2: CPU write at the top address, single ram_we pulse, EXT readback.
        we_cnt = 0;
        cpu_access(1'b1, 9'h1FF, 32'h1234_5678, lat);
        check("t2_write_latency", 32'(lat), 32'd2);
        check("t2_we_pulses", 32'(we_cnt), 32'd1);
        check("t2_we_addr", 32'(we_addr), 32'h1FF);
        ext_access(1'b0, 9'h1FF, '0, 1'b0, lat);
        check("t2_ext_read_latency", 32'(lat), 32'd3);

        // 3: both ports reading continuously without lock alternate, CPU first.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            preload(9'(9'h030 + i), $urandom);
            preload(9'(9'h130 + i), $urandom);
        end
        fork
            for (int i = 0; i < 4; i++) begin
                int l;
                cpu_access(1'b0, 9'(9'h030 + i), '0, l);
            end
            for (int i = 0; i < 4; i++) begin
                int l;
                ext_access(1'b0, 9'(9'h130 + i), '0, 1'b0, l);
            end
        join
        check("t3_ack_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            check("t3_rr_order", 32'(ack_log[i]), 32'(i % 2));

        // 4: EXT lock gives four EXT grants, then one forced CPU slot, repeatedly.
        do_reset();
        fork
            for (int i = 0; i < 2; i++) begin
                int l;
                cpu_access(1'b0, 9'(9'h040 + i), '0, l);
            end
            for (int i = 0; i < 8; i++) begin
                int l;
                ext_access(1'b0, 9'(9'h140 + i), '0, 1'b1, l);
            end
        join
        check("t4_ack_count", 32'(ack_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < ack_log.size(); i++)
            check("t4_lock_order", 32'(ack_log[i]), (i == 4 || i == 9) ? 32'd0 : 32'd1);

        // 5: reset during the write cycle of an EXT write aborts it.
        do_reset();
        ext_we = 1'b1; ext_addr = 9'h020; ext_wdata = 32'hCAFE_F00D; ext_lock = 1'b0;
        ext_req = 1'b1;
        @(posedge clk); #2;
        check("t5_pre_ram_we", 32'(ram_we), 32'd1);
        check("t5_pre_ram_addr", 32'(ram_addr), 32'h020);
        rst_n = 1'b0;
        #1;
        check("t5_ram_we_drop", 32'(ram_we), 32'd0);
        check("t5_no_ext_ack", 32'(ext_ack), 32'd0);
        check("t5_busy_drop", 32'(busy), 32'd0);
        ext_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_ram_unchanged", ram_mem[9'h020], 32'h0);
        init_model();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic: disjoint address halves per port, random lock and gaps.
        fork
            for (int i = 0; i < 40; i++) begin
                int l;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                cpu_access(1'($urandom_range(0, 1)), {1'b0, 8'($urandom)}, $urandom, l);
            end
            for (int i = 0; i < 40; i++) begin
                int l;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                ext_access(1'($urandom_range(0, 1)), {1'b1, 8'($urandom)}, $urandom,
                           1'($urandom_range(0, 1)), l);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("rand_grants_drained", 32'(gnt_exp.size()), 32'd0);
        check("rand_cpu_drained", 32'(cpu_q.size()), 32'd0);
        check("rand_ext_drained", 32'(ext_q.size()), 32'd0);

        // 6: idle cycles keep the RAM quiet and hold the last address.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_ram_we", 32'(ram_we), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ram_addr", 32'(ram_addr), 32'(last_ack_addr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
